// File: rtl/spi_lcd_tx.sv
// Write-only mode-0 SPI transmitter for the LCD panel: one word per request,
// with D/C, chip-select hold across bursts and a post-word settle delay.
module spi_lcd_tx #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 2,
    parameter int SHORT_WAIT = 10,
    parameter int LONG_WAIT  = 2_700_000,
    parameter int WAIT_W     = 22
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dc,
    input  logic              i_we,
    input  logic              i_need_delay,
    input  logic              i_keep_cs,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs,
    output logic              o_dc,
    output logic              o_busy,
    output logic              o_done
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_S   = WAIT_W'(SHORT_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_L   = WAIT_W'(LONG_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic               nd_q, nd_d;
    logic               keep_q, keep_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               dc_q, dc_d;
    logic               done_q, done_d;
    logic [WAIT_W-1:0]  wait_end;

    assign wait_end = nd_q ? WAIT_L : WAIT_S;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        sh_d    = sh_q;
        nd_d    = nd_q;
        keep_d  = keep_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_we) begin
                    sh_d    = i_data << 1;
                    mosi_d  = i_data[DATA_W-1];
                    dc_d    = i_dc;
                    nd_d    = i_need_delay;
                    keep_d  = i_keep_cs;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        mosi_d  = 1'b0;
                        cs_d    = ~keep_q;
                        wait_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        mosi_d = sh_q[DATA_W-1];
                        sh_d   = sh_q << 1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                    // rising edge lands mid-bit so the panel samples stable data
                    if (div_q == DIV_PRE) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == wait_end) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            sh_q    <= '0;
            nd_q    <= 1'b0;
            keep_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            sh_q    <= sh_d;
            nd_q    <= nd_d;
            keep_q  <= keep_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
        end
    end

    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;
    assign o_cs   = cs_q;
    assign o_dc   = dc_q;
    assign o_done = done_q;
    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_lcd_tx.sv
// Bench for spi_lcd_tx: two configurations driven by shared inputs and
// compared every cycle against a waveform model derived from accept time.
module tb_spi_lcd_tx;

    logic        clk = 1'b0;
    logic        rst, we, dc, nd, keep;
    logic [15:0] din;

    logic a_sclk, a_mosi, a_cs, a_dc, a_busy, a_done;
    logic b_sclk, b_mosi, b_cs, b_dc, b_busy, b_done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int a_done_seen = 0;
    int a_done_exp  = 0;

    always #5 clk = ~clk;

    spi_lcd_tx #(
        .DATA_W(8), .CLK_DIV(2), .SHORT_WAIT(10),
        .LONG_WAIT(100), .WAIT_W(22)
    ) u_a (
        .i_clk(clk), .i_rst(rst), .i_data(din[7:0]), .i_dc(dc),
        .i_we(we), .i_need_delay(nd), .i_keep_cs(keep),
        .o_sclk(a_sclk), .o_mosi(a_mosi), .o_cs(a_cs), .o_dc(a_dc),
        .o_busy(a_busy), .o_done(a_done)
    );

    spi_lcd_tx #(
        .DATA_W(16), .CLK_DIV(1), .SHORT_WAIT(10),
        .LONG_WAIT(100), .WAIT_W(22)
    ) u_b (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_dc(dc),
        .i_we(we), .i_need_delay(nd), .i_keep_cs(keep),
        .o_sclk(b_sclk), .o_mosi(b_mosi), .o_cs(b_cs), .o_dc(b_dc),
        .o_busy(b_busy), .o_done(b_done)
    );

    // k = cycles since accept (0 = idle); outputs follow from k by arithmetic
    typedef struct {
        int          w, d, n_s, n_l;
        logic [15:0] data;
        bit          dc, nd, keep, cs;
        int          k;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m);
        int s, n;
        s = m.w * 2 * m.d;
        n = m.nd ? m.n_l : m.n_s;
        if (rst) begin
            m.k = 0; m.cs = 1; m.dc = 0;
        end else if (m.k == 0) begin
            if (we) begin
                m.k = 1; m.data = din; m.dc = dc;
                m.nd = nd; m.keep = keep; m.cs = 0;
            end
        end else if (m.k == s + n + 1) begin
            m.k = 0;
        end else begin
            m.k++;
            if (m.k == s + 1) m.cs = !m.keep;
        end
        return m;
    endfunction

    // packed as {cs, sclk, mosi, dc, busy, done}
    function automatic logic [5:0] expv(mdl_t m);
        int s, n, b, ph;
        s = m.w * 2 * m.d;
        n = m.nd ? m.n_l : m.n_s;
        if (m.k == 0)
            return {m.cs, 1'b0, 1'b0, m.dc, 1'b0, 1'b0};
        if (m.k <= s) begin
            b  = (m.k - 1) / (2 * m.d);
            ph = (m.k - 1) % (2 * m.d);
            return {1'b0, ph >= m.d, m.data[m.w-1-b], m.dc, 1'b1, 1'b0};
        end
        if (m.k <= s + n)
            return {m.cs, 1'b0, 1'b0, m.dc, 1'b1, 1'b0};
        return {m.cs, 1'b0, 1'b0, m.dc, 1'b1, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        logic [5:0] ea;
        @(posedge clk);
        ma = step(ma);
        mb = step(mb);
        cyc++;
        @(negedge clk);
        ea = expv(ma);
        check("a_pins", {26'b0, a_cs, a_sclk, a_mosi, a_dc, a_busy, a_done},
              {26'b0, ea});
        check("b_pins", {26'b0, b_cs, b_sclk, b_mosi, b_dc, b_busy, b_done},
              {26'b0, expv(mb)});
        if (a_done === 1'b1) a_done_seen++;
        if (ea[0]) a_done_exp++;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && !(ma.k == 0 && mb.k == 0); i++) cycle();
        check("idle_timeout", {31'b0, ma.k == 0 && mb.k == 0}, 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input bit c, input bit n,
                        input bit kp);
        din = d; dc = c; nd = n; keep = kp; we = 1;
        cycle();
        we = 0;
    endtask

    initial begin
        ma = '{w: 8, d: 2, n_s: 10, n_l: 100, data: 16'h0,
               dc: 0, nd: 0, keep: 0, cs: 1, k: 0};
        mb = '{w: 16, d: 1, n_s: 10, n_l: 100, data: 16'h0,
               dc: 0, nd: 0, keep: 0, cs: 1, k: 0};
        rst = 1; we = 0; dc = 0; nd = 0; keep = 0; din = '0;
        cycle();
        cycle();
        rst = 0;
        cycle();

        // plain command word, short settle
        send(16'h00A5, 0, 0, 0);
        wait_idle(200);
        cycle();

        // data word with long settle
        send(16'h1234, 1, 1, 0);
        wait_idle(400);

        // burst: CS held low between words
        send(16'h002C, 1, 0, 1);
        wait_idle(200);
        send(16'h0055, 1, 0, 0);
        wait_idle(200);

        // request during SHIFT is dropped
        send(16'h003C, 0, 0, 0);
        repeat (6) cycle();
        send(16'hFFFF, 1, 1, 1);
        wait_idle(200);

        // reset mid-word at bit 3 of the 8-bit instance
        send(16'h00C3, 1, 0, 1);
        repeat (12) cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        send(16'h8001, 0, 0, 0);
        wait_idle(200);

        // request on the DONE cycle is dropped
        send(16'h005A, 0, 0, 0);
        for (int i = 0; i < 200 && ma.k != 43; i++) cycle();
        we = 1; din = 16'h00FF;
        cycle();
        we = 0;
        wait_idle(200);

        for (int i = 0; i < 4000; i++) begin
            we   = ($urandom_range(0, 3) == 0);
            din  = 16'($urandom);
            dc   = 1'($urandom);
            keep = 1'($urandom);
            nd   = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 0; we = 0;
        wait_idle(400);

        check("a_done_count", a_done_seen, a_done_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
